// File: rtl/bn_result_writer_pkg.sv
// ---------------------------------------------------------------------------
// bn_result_writer_pkg
// Shared TPU command codes for the batch-norm block and its result writer.
// The SET_BN_* codes configure the batch-norm stage; the SET_WB_* / WB_CLEAR
// codes configure the write-back path (bn_result_writer).
// ---------------------------------------------------------------------------
package bn_result_writer_pkg;

  localparam int TPU_CMD_W = 8;

  typedef enum logic [TPU_CMD_W-1:0] {
    SET_BN_MEAN      = 8'h20,
    SET_BN_VAR       = 8'h21,
    SET_BN_GAMMA     = 8'h22,
    SET_BN_BETA      = 8'h23,
    SET_WB_BASE_ADDR = 8'h30,
    SET_WB_STRIDE    = 8'h31,
    WB_CLEAR         = 8'h32
  } tpu_cmd_e;

endpackage

// File: rtl/bn_result_writer_if.sv
// ---------------------------------------------------------------------------
// bn_result_writer_if
// Ready/valid write port toward the output buffer SRAM.
//   wr_valid : word valid (master -> slave)
//   wr_ready : word accepted when high together with wr_valid (slave -> master)
//   wr_addr  : write address
//   wr_data  : write data (one 64-bit lane = 4 fp16 values)
// ---------------------------------------------------------------------------
interface bn_result_writer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 64
) ();

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/bn_group_fifo.sv
// ---------------------------------------------------------------------------
// bn_group_fifo
// Synchronous FIFO holding whole result groups (all lanes of one group in one
// entry). The head entry is visible combinationally on head_data so the
// serializer can present lane 0 in the cycle right after capture.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push/push_data: write one entry (caller guarantees space, or a same-cycle pop)
//   pop           : retire the head entry (caller guarantees non-empty)
//   flush         : empty the FIFO (wins over push/pop)
//   head_data     : oldest entry
//   full, empty, count : occupancy
// ---------------------------------------------------------------------------
module bn_group_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;

  // Storage carries no reset; only the pointers define what is valid.
  // A push into a full FIFO only happens with a same-cycle pop, so the slot
  // written is the one being retired.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign full      = (count_reg == DEPTH_C);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;

endmodule

// File: rtl/bn_result_writer.sv
// ---------------------------------------------------------------------------
// bn_result_writer
// Captures each batch-norm result group (LANES x 64-bit lanes) into a small
// FIFO and serializes it as LANES words on a ready/valid write port, with
// addresses generated from a programmable base and stride.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   tpu_cmd_valid/tpu_cmd  : command strobe and code (SET_WB_BASE_ADDR,
//                            SET_WB_STRIDE, WB_CLEAR; others ignored)
//   tpu_param_1_in         : command parameter (base or stride)
//   tpu_param_2_in         : reserved
//   batchNormResultValid   : one-cycle strobe per result group
//   batchNormResult_r      : result lanes [0:LANES-1]
//   wr                     : write port (master side)
//   busy_o                 : FIFO holds at least one group
//   overflow_o             : sticky, a group was dropped because the FIFO was full
//   words_written_o        : count of accepted words, wraps
// ---------------------------------------------------------------------------
module bn_result_writer
  import bn_result_writer_pkg::*;
#(
  parameter int ACLEN      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      tpu_cmd_valid,
  input  logic [ACLEN-1:0]          tpu_cmd,
  input  logic [DATA_WIDTH-1:0]     tpu_param_1_in,
  input  logic [DATA_WIDTH-1:0]     tpu_param_2_in,
  input  logic                      batchNormResultValid,
  input  logic [DATA_WIDTH*4-1:0]   batchNormResult_r [LANES],
  bn_result_writer_if.master        wr,
  output logic                      busy_o,
  output logic                      overflow_o,
  output logic [15:0]               words_written_o
);

  localparam int WORD_W = DATA_WIDTH * 4;
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [CNT_W-1:0] ONE_ENTRY = CNT_W'(1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_e;

  ser_state_e state_reg, state_next;

  logic [ADDR_WIDTH-1:0]     base_reg;
  logic [ADDR_WIDTH-1:0]     stride_reg;
  logic [ADDR_WIDTH-1:0]     cur_addr_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic [15:0]               words_reg;
  logic                      overflow_reg;

  logic [LANES*WORD_W-1:0]   push_data;
  logic [LANES*WORD_W-1:0]   head_data;
  logic [WORD_W-1:0]         head_lane [LANES];
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;

  logic cmd_clear, cmd_base, cmd_stride;
  logic wr_valid, xfer, pop, push_req, push, drop;

  // Pack the incoming lanes into one FIFO entry and unpack the head entry.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign push_data[gi*WORD_W +: WORD_W] = batchNormResult_r[gi];
    assign head_lane[gi]                  = head_data[gi*WORD_W +: WORD_W];
  end

  // Command decode. Base/stride changes are refused while words are pending
  // so a group is never split across two address sequences.
  assign cmd_clear  = tpu_cmd_valid && (tpu_cmd == ACLEN'(WB_CLEAR));
  assign cmd_base   = tpu_cmd_valid && (tpu_cmd == ACLEN'(SET_WB_BASE_ADDR)) && !busy_o;
  assign cmd_stride = tpu_cmd_valid && (tpu_cmd == ACLEN'(SET_WB_STRIDE)) && !busy_o;

  // A clear cancels both the transfer and the capture in the same cycle.
  assign wr_valid = (state_reg == S_SEND);
  assign xfer     = wr_valid && wr.wr_ready && !cmd_clear;
  assign pop      = xfer && (idx_reg == LAST_IDX);
  assign push_req = batchNormResultValid && !cmd_clear;
  // A full FIFO still accepts when the head's last lane leaves this cycle.
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  bn_group_fifo #(
    .WIDTH (LANES * WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (cmd_clear),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (push) state_next = S_SEND;
      end
      S_SEND: begin
        // Leave only when the last queued group finishes and nothing new arrives.
        if (pop && (fifo_count == ONE_ENTRY) && !push) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (cmd_clear) state_next = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_reg     <= '0;
      stride_reg   <= ADDR_WIDTH'(1);
      cur_addr_reg <= '0;
      idx_reg      <= '0;
      words_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (cmd_clear) begin
      cur_addr_reg <= base_reg;
      idx_reg      <= '0;
      words_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      // cmd_base only fires when idle, so it never collides with a transfer.
      if (cmd_base) begin
        base_reg     <= ADDR_WIDTH'(tpu_param_1_in);
        cur_addr_reg <= ADDR_WIDTH'(tpu_param_1_in);
      end else if (xfer) begin
        cur_addr_reg <= cur_addr_reg + stride_reg;
      end
      if (cmd_stride) stride_reg <= ADDR_WIDTH'(tpu_param_1_in);
      if (xfer) begin
        idx_reg   <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        words_reg <= words_reg + 16'd1;
      end
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign wr.wr_valid     = wr_valid;
  assign wr.wr_addr      = cur_addr_reg;
  assign wr.wr_data      = wr_valid ? head_lane[idx_reg] : '0;
  assign busy_o          = !fifo_empty;
  assign overflow_o      = overflow_reg;
  assign words_written_o = words_reg;

  // Parameter 2 is reserved for future write-back options.
  logic unused_param_2;
  assign unused_param_2 = ^tpu_param_2_in;

endmodule

// File: tb/tb_bn_result_writer.sv
// ---------------------------------------------------------------------------
// tb_bn_result_writer
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences (overflow, async reset, full push/pop), then randomized traffic
// against a word-queue reference model.
// ---------------------------------------------------------------------------
module tb_bn_result_writer;
  import bn_result_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cv;
  logic [7:0]  cc;
  logic [15:0] cp;
  logic [15:0] cp2;
  logic        bnv;
  logic        rdy;
  logic [63:0] bn_lanes [4];
  logic        busy;
  logic        ovf;
  logic [15:0] words;

  int n_checks = 0;
  int n_errors = 0;

  bn_result_writer_if #(.ADDR_WIDTH(16), .WORD_WIDTH(64)) wr_if ();
  assign wr_if.wr_ready = rdy;

  bn_result_writer #(
    .ACLEN(8), .DATA_WIDTH(16), .LANES(4), .FIFO_DEPTH(4), .ADDR_WIDTH(16)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_ni),
    .tpu_cmd_valid        (cv),
    .tpu_cmd              (cc),
    .tpu_param_1_in       (cp),
    .tpu_param_2_in       (cp2),
    .batchNormResultValid (bnv),
    .batchNormResult_r    (bn_lanes),
    .wr                   (wr_if),
    .busy_o               (busy),
    .overflow_o           (ovf),
    .words_written_o      (words)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [7:0]  cmd;
    logic [15:0] prm;
    logic        bnv;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_addr;
    int          e_lane;   // -1: no word presented (data reads 0)
    logic        e_busy;
    logic [15:0] e_words;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] basic_lanes [4];
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic c_v, input logic [7:0] c, input logic [15:0] p,
                     input logic b, input logic r, input logic ev,
                     input logic [15:0] ea, input int el, input logic eb,
                     input logic [15:0] ew);
    vec_t v;
    v.cv = c_v; v.cmd = c; v.prm = p; v.bnv = b; v.rdy = r;
    v.e_valid = ev; v.e_addr = ea; v.e_lane = el; v.e_busy = eb; v.e_words = ew;
    tbl.push_back(v);
  endtask

  function automatic logic [63:0] gdat(input int g, input int l);
    return {16'h1000 + 16'(g), 16'h2000 + 16'(l), 16'hface, 16'(g * 4 + l)};
  endfunction

  task automatic set_group(input int g);
    for (int l = 0; l < 4; l++) begin
      bn_lanes[l] = gdat(g, l);
      exp_q.push_back(gdat(g, l));
    end
  endtask

  task automatic cmd(input logic [7:0] c, input logic [15:0] p);
    @(negedge clk);
    cv = 1'b1; cc = c; cp = p;
    @(negedge clk);
    cv = 1'b0; cc = '0; cp = '0;
  endtask

  // Holds ready high and checks every presented word against exp_q in order.
  // When inject_after > 0, a new group is captured in the cycle that word
  // number inject_after is accepted.
  task automatic stream(input logic [15:0] a0, input logic [15:0] step,
                        input int inject_after, input int inj_g);
    logic [15:0] a;
    int seen;
    int cyc;
    a = a0; seen = 0; cyc = 0;
    while (exp_q.size() != 0 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      bnv = 1'b0;
      rdy = 1'b1;
      if (wr_if.wr_valid) begin
        chk("stream_data", wr_if.wr_data, exp_q[0]);
        chk("stream_addr", 64'(wr_if.wr_addr), 64'(a));
        $display("word %0d: addr=%h data=%h", seen, wr_if.wr_addr, wr_if.wr_data);
        void'(exp_q.pop_front());
        a = a + step;
        seen++;
        if (inject_after > 0 && seen == inject_after) begin
          set_group(inj_g);
          bnv = 1'b1;
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL stream_timeout: got %0d words left, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    rdy = 1'b0;
    bnv = 1'b0;
    chk("stream_valid_drop", 64'(wr_if.wr_valid), 64'd0);
  endtask

  // Reference model state for the randomized phase
  logic [63:0] m_q[$];
  logic [15:0] m_base, m_stride, m_addr, m_words;
  logic        m_ovf;

  initial begin
    rst_ni = 1'b0; cv = 1'b0; cc = '0; cp = '0; cp2 = '0; bnv = 1'b0; rdy = 1'b0;
    for (int l = 0; l < 4; l++) bn_lanes[l] = '0;
    basic_lanes[0] = 64'h4200_4600_4880_4a00;
    basic_lanes[1] = 64'h3c00_4000_4200_4400;
    basic_lanes[2] = 64'h4500_4600_4700_4800;
    basic_lanes[3] = 64'hbc00_c000_c200_c400;

    // Each row: inputs applied this cycle, outputs expected entering this cycle.
    add(1, SET_WB_BASE_ADDR, 16'h0100, 0, 0, 0, 16'h0000, -1, 0, 0);
    add(1, SET_WB_STRIDE,    16'h0001, 0, 0, 0, 16'h0100, -1, 0, 0);
    add(0, 8'h00, 0, 1, 1, 0, 16'h0100, -1, 0, 0);   // capture
    add(0, 8'h00, 0, 0, 1, 1, 16'h0100,  0, 1, 0);   // lane 0 one cycle later
    add(0, 8'h00, 0, 0, 1, 1, 16'h0101,  1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 1, 16'h0102,  2, 1, 2);
    add(0, 8'h00, 0, 0, 1, 1, 16'h0103,  3, 1, 3);
    add(1, WB_CLEAR, 0, 0, 0, 0, 16'h0104, -1, 0, 4);
    add(0, 8'h00, 0, 1, 0, 0, 16'h0100, -1, 0, 0);   // backpressure group
    for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 0, 0, 1, 16'h0100, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 16'h0100,  0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 16'h0101,  1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 1, 16'h0102,  2, 1, 2);
    add(0, 8'h00, 0, 0, 1, 1, 16'h0103,  3, 1, 3);
    add(1, SET_WB_STRIDE, 16'h0004, 0, 0, 0, 16'h0104, -1, 0, 4);
    add(1, WB_CLEAR, 0, 0, 0, 0, 16'h0104, -1, 0, 4);
    add(0, 8'h00, 0, 1, 1, 0, 16'h0100, -1, 0, 0);
    add(1, SET_WB_STRIDE, 16'h0009, 0, 1, 1, 16'h0100, 0, 1, 0);  // ignored: busy
    add(0, 8'h00, 0, 0, 1, 1, 16'h0104,  1, 1, 1);
    add(1, WB_CLEAR, 0, 0, 1, 1, 16'h0108, 2, 1, 2);  // clear beats transfer
    add(0, 8'h00, 0, 1, 1, 0, 16'h0100, -1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 1, 16'h0100,  0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 16'h0104,  1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 1, 16'h0108,  2, 1, 2);
    add(0, 8'h00, 0, 0, 1, 1, 16'h010c,  3, 1, 3);
    add(1, 8'hff, 16'h5555, 0, 0, 0, 16'h0110, -1, 0, 4);  // unknown code
    add(1, WB_CLEAR, 0, 1, 0, 0, 16'h0110, -1, 0, 4);      // clear beats capture
    add(0, 8'h00, 0, 0, 1, 0, 16'h0100, -1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0, 16'h0100, -1, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(wr_if.wr_valid), 64'd0);
    chk("reset_addr",  64'(wr_if.wr_addr), 64'd0);
    chk("reset_data",  wr_if.wr_data, 64'd0);
    chk("reset_busy",  64'(busy), 64'd0);
    chk("reset_ovf",   64'(ovf), 64'd0);
    chk("reset_words", 64'(words), 64'd0);
    rst_ni = 1'b1;

    // Directed table
    for (int l = 0; l < 4; l++) bn_lanes[l] = basic_lanes[l];
    for (int i = 0; i < tbl.size(); i++) begin
      logic [63:0] ed;
      @(negedge clk);
      ed = (tbl[i].e_lane < 0) ? 64'd0 : basic_lanes[tbl[i].e_lane];
      $display("vec %0d: valid=%0b addr=%h data=%h busy=%0b words=%0d",
               i, wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data, busy, words);
      chk("tbl_valid", 64'(wr_if.wr_valid), 64'(tbl[i].e_valid));
      chk("tbl_addr",  64'(wr_if.wr_addr), 64'(tbl[i].e_addr));
      chk("tbl_data",  wr_if.wr_data, ed);
      chk("tbl_busy",  64'(busy), 64'(tbl[i].e_busy));
      chk("tbl_ovf",   64'(ovf), 64'd0);
      chk("tbl_words", 64'(words), 64'(tbl[i].e_words));
      cv = tbl[i].cv; cc = tbl[i].cmd; cp = tbl[i].prm; bnv = tbl[i].bnv; rdy = tbl[i].rdy;
    end
    @(negedge clk);
    cv = 1'b0; cc = '0; cp = '0; bnv = 1'b0; rdy = 1'b0;

    // Overflow: five groups with ready low, fifth dropped
    cmd(SET_WB_STRIDE, 16'h0001);
    for (int g = 1; g <= 5; g++) begin
      @(negedge clk);
      set_group(g);
      bnv = 1'b1; rdy = 1'b0;
    end
    repeat (4) void'(exp_q.pop_back());   // group 5 is expected to be dropped
    @(negedge clk);
    bnv = 1'b0;
    chk("ovf_set",  64'(ovf), 64'd1);
    chk("ovf_busy", 64'(busy), 64'd1);
    stream(16'h0100, 16'h0001, 0, 0);
    chk("ovf_words",  64'(words), 64'd16);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    chk("ovf_idle",   64'(busy), 64'd0);

    // Asynchronous reset in the middle of SEND
    @(negedge clk);
    set_group(7); exp_q.delete();
    bnv = 1'b1; rdy = 1'b1;
    @(negedge clk);
    bnv = 1'b0;
    chk("arst_pre_valid", 64'(wr_if.wr_valid), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 64'(wr_if.wr_valid), 64'd0);
    chk("arst_busy",  64'(busy), 64'd0);
    chk("arst_ovf",   64'(ovf), 64'd0);
    chk("arst_words", 64'(words), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1; rdy = 1'b0;
    chk("arst_addr", 64'(wr_if.wr_addr), 64'd0);
    set_group(8);
    bnv = 1'b1;
    stream(16'h0000, 16'h0001, 0, 0);    // base 0, stride 1 after reset
    chk("arst_words_after", 64'(words), 64'd4);

    // Full FIFO accepts a group while the head's last lane leaves
    cmd(WB_CLEAR, 16'h0000);
    chk("sim_ovf_cleared", 64'(ovf), 64'd0);
    cmd(SET_WB_BASE_ADDR, 16'h0200);
    for (int g = 1; g <= 4; g++) begin
      @(negedge clk);
      set_group(g);
      bnv = 1'b1; rdy = 1'b0;
    end
    stream(16'h0200, 16'h0001, 4, 5);
    chk("sim_ovf",   64'(ovf), 64'd0);
    chk("sim_words", 64'(words), 64'd20);

    // Randomized traffic against the word-queue model
    cmd(WB_CLEAR, 16'h0000);
    m_q.delete();
    m_base = 16'h0200; m_stride = 16'h0001; m_addr = 16'h0200; m_words = '0; m_ovf = 1'b0;
    for (int i = 0; i < 640; i++) begin
      int r;
      logic busy_m, c_clr, c_base, c_str;
      @(negedge clk);
      busy_m = (m_q.size() != 0);
      chk("rnd_valid", 64'(wr_if.wr_valid), 64'(busy_m));
      chk("rnd_busy",  64'(busy), 64'(busy_m));
      chk("rnd_ovf",   64'(ovf), 64'(m_ovf));
      chk("rnd_words", 64'(words), 64'(m_words));
      if (busy_m) begin
        chk("rnd_data", wr_if.wr_data, m_q[0]);
        chk("rnd_addr", 64'(wr_if.wr_addr), 64'(m_addr));
      end
      r = $urandom_range(0, 99);
      c_clr  = (i < 600) && (r < 2);
      c_base = (i < 600) && (r >= 2) && (r < 5);
      c_str  = (i < 600) && (r >= 5) && (r < 8);
      cv = c_clr || c_base || c_str;
      cc = c_clr ? 8'(WB_CLEAR) : c_base ? 8'(SET_WB_BASE_ADDR) : c_str ? 8'(SET_WB_STRIDE) : 8'h00;
      cp = c_str ? 16'($urandom_range(0, 7)) : 16'($urandom);
      bnv = (i < 600) && ($urandom_range(0, 99) < 35);
      rdy = (i >= 600) || ($urandom_range(0, 99) < 60);
      for (int l = 0; l < 4; l++) bn_lanes[l] = {$urandom, $urandom};
      if (c_clr) begin
        m_q.delete(); m_addr = m_base; m_words = '0; m_ovf = 1'b0;
      end else begin
        if (c_base && !busy_m) begin m_base = cp; m_addr = cp; end
        if (c_str && !busy_m) m_stride = cp;
        if (busy_m && rdy) begin
          void'(m_q.pop_front());
          m_addr = m_addr + m_stride;
          m_words = m_words + 16'd1;
        end
        if (bnv) begin
          if ((m_q.size() + 3) / 4 < 4) begin
            for (int l = 0; l < 4; l++) m_q.push_back(bn_lanes[l]);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    cv = 1'b0; bnv = 1'b0; rdy = 1'b0;
    chk("rnd_drained", 64'(busy), 64'd0);
    $display("random phase: %0d words accepted since last clear", m_words);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
